// File: rtl/sys_defs.sv
// Shared bus encodings, cache geometry and MSHR/prefetch types for the I-side.
package sys_defs;

    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    localparam int ICACHE_IDX_W  = 4;
    localparam int ICACHE_TAG_W  = 9;
    localparam int ICACHE_LINE_W = 13;

    typedef struct packed {
        logic                     valid;
        logic [3:0]               mem_tag;
        logic [ICACHE_LINE_W-1:0] line;
    } mshr_entry_t;

    typedef enum logic {IDLE, PREFETCH} pf_state_t;

    function automatic logic [63:0] line_to_addr(input logic [ICACHE_LINE_W-1:0] line);
        return {48'b0, line, 3'b0};
    endfunction

endpackage

// File: rtl/icache_mshr_table.sv
// Outstanding-load table: line/tag lookups, lowest-free allocation and free on return.
module icache_mshr_table
    import sys_defs::*;
#(
    parameter int NUM_MSHR = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alloc_en,
    input  logic [3:0]               alloc_tag,
    input  logic [ICACHE_LINE_W-1:0] alloc_line,
    input  logic [ICACHE_LINE_W-1:0] dmd_line,
    input  logic [ICACHE_LINE_W-1:0] pf_line,
    input  logic [3:0]               ret_tag,
    input  logic                     free_en,
    output logic                     dmd_hit,
    output logic                     pf_hit,
    output logic                     tag_hit,
    output logic [ICACHE_LINE_W-1:0] tag_line,
    output logic                     full,
    output logic [$clog2(NUM_MSHR)-1:0] free_idx
);

    localparam int IW = $clog2(NUM_MSHR);

    mshr_entry_t mshr_q [NUM_MSHR];
    mshr_entry_t mshr_d [NUM_MSHR];
    logic [IW-1:0] tag_idx;
    logic          found;

    always_comb begin
        dmd_hit  = 1'b0;
        pf_hit   = 1'b0;
        tag_hit  = 1'b0;
        tag_line = '0;
        tag_idx  = '0;
        full     = 1'b1;
        free_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (mshr_q[i].valid) begin
                if (mshr_q[i].line == dmd_line) dmd_hit = 1'b1;
                if (mshr_q[i].line == pf_line)  pf_hit  = 1'b1;
                if (ret_tag != 4'd0 && mshr_q[i].mem_tag == ret_tag) begin
                    tag_hit  = 1'b1;
                    tag_line = mshr_q[i].line;
                    tag_idx  = IW'(i);
                end
            end else if (!found) begin
                found    = 1'b1;
                full     = 1'b0;
                free_idx = IW'(i);
            end
        end
    end

    // A returning entry stays valid until the edge, so it is never the free_idx this cycle.
    always_comb begin
        for (int i = 0; i < NUM_MSHR; i++) mshr_d[i] = mshr_q[i];
        if (free_en)  mshr_d[tag_idx].valid = 1'b0;
        if (alloc_en) mshr_d[free_idx] = '{valid: 1'b1, mem_tag: alloc_tag, line: alloc_line};
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (!reset) mshr_q[i] <= '0;
            else        mshr_q[i] <= mshr_d[i];
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// I-cache miss/prefetch controller: hit/forward path, demand loads, next-line prefetch, line fill.
//   state    | meaning
//   IDLE     | no prefetch window open
//   PREFETCH | walking pf_ptr for pf_left more lines
module icache_ctrl
    import sys_defs::*;
#(
    parameter int NUM_MSHR = 4,
    parameter int PF_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    proc2Icache_req,
    input  logic [63:0]             proc2Icache_addr,
    output logic [63:0]             Icache_data_out,
    output logic                    Icache_valid_out,
    output logic [ICACHE_IDX_W-1:0] cache_rd_idx,
    output logic [ICACHE_TAG_W-1:0] cache_rd_tag,
    input  logic [63:0]             cache_rd_data,
    input  logic                    cache_rd_valid,
    output logic [ICACHE_IDX_W-1:0] cache_pf_idx,
    output logic [ICACHE_TAG_W-1:0] cache_pf_tag,
    input  logic                    cache_pf_valid,
    output logic                    cache_wr_en,
    output logic [ICACHE_IDX_W-1:0] cache_wr_idx,
    output logic [ICACHE_TAG_W-1:0] cache_wr_tag,
    output logic [63:0]             cache_wr_data,
    input  logic                    Imem_grant,
    output logic [1:0]              proc2Imem_command,
    output logic [63:0]             proc2Imem_addr,
    input  logic [3:0]              Imem2proc_response,
    input  logic [3:0]              Imem2proc_tag,
    input  logic [63:0]             Imem2proc_data
);

    localparam int PL_W = $clog2(PF_DEPTH + 1);

    pf_state_t                state_q, state_d;
    logic [ICACHE_LINE_W-1:0] pf_ptr_q, pf_ptr_d;
    logic [PL_W-1:0]          pf_left_q, pf_left_d;

    logic [ICACHE_LINE_W-1:0] fetch_line, tag_line, alloc_line;
    logic [$clog2(NUM_MSHR)-1:0] free_idx;
    logic dmd_hit, pf_hit, tag_hit, full;
    logic rd_miss, fwd, demand_miss, can_issue, pf_skip;
    logic dmd_issue, pf_issue, accepted, pf_step;
    logic unused_addr_bits;

    assign fetch_line       = proc2Icache_addr[15:3];
    assign unused_addr_bits = ^{proc2Icache_addr[63:16], proc2Icache_addr[2:0], free_idx};
    assign cache_rd_idx     = fetch_line[3:0];
    assign cache_rd_tag     = fetch_line[12:4];
    assign cache_pf_idx     = pf_ptr_q[3:0];
    assign cache_pf_tag     = pf_ptr_q[12:4];

    assign rd_miss     = proc2Icache_req & ~cache_rd_valid;
    assign fwd         = rd_miss & tag_hit & (tag_line == fetch_line);
    assign demand_miss = rd_miss & ~dmd_hit;
    assign can_issue   = reset & Imem_grant & ~full;
    assign pf_skip     = cache_pf_valid | pf_hit;
    assign dmd_issue   = can_issue & demand_miss;
    assign pf_issue    = can_issue & ~demand_miss & (state_q == PREFETCH) & ~pf_skip;
    assign accepted    = Imem2proc_response != 4'd0;
    assign alloc_line  = dmd_issue ? fetch_line : pf_ptr_q;
    assign pf_step     = (state_q == PREFETCH) & ~dmd_issue & (pf_skip | (pf_issue & accepted));

    icache_mshr_table #(.NUM_MSHR(NUM_MSHR)) u_mshr (
        .clock      (clock),
        .reset      (reset),
        .alloc_en   ((dmd_issue | pf_issue) & accepted),
        .alloc_tag  (Imem2proc_response),
        .alloc_line (alloc_line),
        .dmd_line   (fetch_line),
        .pf_line    (pf_ptr_q),
        .ret_tag    (Imem2proc_tag),
        .free_en    (tag_hit),
        .dmd_hit    (dmd_hit),
        .pf_hit     (pf_hit),
        .tag_hit    (tag_hit),
        .tag_line   (tag_line),
        .full       (full),
        .free_idx   (free_idx)
    );

    assign proc2Imem_command = (dmd_issue | pf_issue) ? BUS_LOAD : BUS_NONE;
    assign proc2Imem_addr    = (dmd_issue | pf_issue) ? line_to_addr(alloc_line) : 64'd0;

    assign Icache_valid_out = reset & proc2Icache_req & (cache_rd_valid | fwd);
    assign Icache_data_out  = (!reset)                                  ? 64'd0 :
                              (proc2Icache_req && cache_rd_valid)       ? cache_rd_data :
                              fwd                                       ? Imem2proc_data : 64'd0;

    assign cache_wr_en   = reset & tag_hit;
    assign cache_wr_idx  = tag_line[3:0];
    assign cache_wr_tag  = tag_line[12:4];
    assign cache_wr_data = Imem2proc_data;

    // A fresh demand miss always reopens the window just past its own line.
    always_comb begin
        state_d   = state_q;
        pf_ptr_d  = pf_ptr_q;
        pf_left_d = pf_left_q;
        if (dmd_issue && accepted) begin
            state_d   = PREFETCH;
            pf_ptr_d  = fetch_line + 13'd1;
            pf_left_d = PL_W'(PF_DEPTH);
        end else if (pf_step) begin
            pf_ptr_d  = pf_ptr_q + 13'd1;
            pf_left_d = pf_left_q - PL_W'(1);
            if (pf_left_q == PL_W'(1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            pf_ptr_q  <= '0;
            pf_left_q <= '0;
        end else begin
            state_q   <= state_d;
            pf_ptr_q  <= pf_ptr_d;
            pf_left_q <= pf_left_d;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed-vector bench for icache_ctrl: the bench plays cache array and memory port.
module tb_icache_ctrl;
    import sys_defs::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [63:0] addr;
    logic [63:0] data_out;
    logic        valid_out;
    logic [3:0]  rd_idx, pf_idx, wr_idx;
    logic [8:0]  rd_tag, pf_tag, wr_tag;
    logic [63:0] rd_data, wr_data;
    logic        rd_valid, pf_valid, wr_en;
    logic        grant;
    logic [1:0]  cmd;
    logic [63:0] mem_addr;
    logic [3:0]  response, ret_tag;
    logic [63:0] ret_data;

    int vec  = 0;
    int miss = 0;

    localparam logic [63:0] D0 = 64'hA5A5_0000_1111_2222;
    localparam logic [63:0] D1 = 64'h0BAD_F00D_3333_4444;

    always #5 clock = ~clock;

    icache_ctrl #(.NUM_MSHR(4), .PF_DEPTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .proc2Icache_req    (req),
        .proc2Icache_addr   (addr),
        .Icache_data_out    (data_out),
        .Icache_valid_out   (valid_out),
        .cache_rd_idx       (rd_idx),
        .cache_rd_tag       (rd_tag),
        .cache_rd_data      (rd_data),
        .cache_rd_valid     (rd_valid),
        .cache_pf_idx       (pf_idx),
        .cache_pf_tag       (pf_tag),
        .cache_pf_valid     (pf_valid),
        .cache_wr_en        (wr_en),
        .cache_wr_idx       (wr_idx),
        .cache_wr_tag       (wr_tag),
        .cache_wr_data      (wr_data),
        .Imem_grant         (grant),
        .proc2Imem_command  (cmd),
        .proc2Imem_addr     (mem_addr),
        .Imem2proc_response (response),
        .Imem2proc_tag      (ret_tag),
        .Imem2proc_data     (ret_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        if (obs !== exp) begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        req = 1'b0; addr = 64'd0; rd_valid = 1'b0; rd_data = 64'd0; pf_valid = 1'b0;
        grant = 1'b0; response = 4'd0; ret_tag = 4'd0; ret_data = 64'd0;
    endtask

    task automatic step();
        @(negedge clock);
        quiet();
    endtask

    initial begin
        reset = 1'b0;
        quiet();
        @(negedge clock);

        // reset held with activity on every input
        req = 1; addr = 64'h1000; grant = 1; response = 4'd3; ret_tag = 4'd3; ret_data = D0; #1;
        chk("rst_cmd", cmd, BUS_NONE);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_data", data_out, 64'd0);
        step(); reset = 1'b1;

        // cold miss at 0x1000, tag 3
        req = 1; addr = 64'h1000; grant = 1; response = 4'd3; #1;
        chk("cold_cmd", cmd, BUS_LOAD);
        chk("cold_addr", mem_addr, 64'h1000);
        chk("cold_rd_idx", rd_idx, 4'h0);
        chk("cold_rd_tag", rd_tag, 9'h020);
        chk("cold_valid", valid_out, 1'b0);
        step();

        // tag 3 returns and forwards while the first prefetch (0x1008) issues
        req = 1; addr = 64'h1000; grant = 1; response = 4'd4; ret_tag = 4'd3; ret_data = D0; #1;
        chk("fwd_valid", valid_out, 1'b1);
        chk("fwd_data", data_out, D0);
        chk("fill_wr_en", wr_en, 1'b1);
        chk("fill_idx", wr_idx, 4'h0);
        chk("fill_tag", wr_tag, 9'h020);
        chk("fill_data", wr_data, D0);
        chk("pf1_cmd", cmd, BUS_LOAD);
        chk("pf1_addr", mem_addr, 64'h1008);
        chk("pf1_idx", pf_idx, 4'h1);
        chk("pf1_tag", pf_tag, 9'h020);
        step();
        grant = 1; response = 4'd5; #1;
        chk("pf2_addr", mem_addr, 64'h1010);
        step();
        grant = 1; response = 4'd6; #1;
        chk("pf3_addr", mem_addr, 64'h1018);
        step();
        grant = 1; response = 4'd7; #1;
        chk("pf4_cmd", cmd, BUS_LOAD);
        chk("pf4_addr", mem_addr, 64'h1020);
        step();
        grant = 1; response = 4'd8; #1;
        chk("pf_done_idle", cmd, BUS_NONE);
        step();

        // table full: new miss at 0x2000 blocked
        req = 1; addr = 64'h2000; grant = 1; response = 4'd9; #1;
        chk("full_cmd", cmd, BUS_NONE);
        step();
        req = 1; addr = 64'h2000; grant = 1; response = 4'd9; ret_tag = 4'd4; ret_data = D1; #1;
        chk("full_ret_wr_en", wr_en, 1'b1);
        chk("full_ret_idx", wr_idx, 4'h1);
        chk("full_ret_cmd", cmd, BUS_NONE);
        chk("full_ret_valid", valid_out, 1'b0);
        step();
        req = 1; addr = 64'h2000; grant = 1; response = 4'd9; #1;
        chk("after_free_cmd", cmd, BUS_LOAD);
        chk("after_free_addr", mem_addr, 64'h2000);
        step();

        // hit path, stale return, prefetch stalled by full table
        req = 1; addr = 64'h3008; rd_valid = 1; rd_data = 64'hDEAD; grant = 1; response = 4'd12;
        ret_tag = 4'hC; ret_data = D1; #1;
        chk("hit_valid", valid_out, 1'b1);
        chk("hit_data", data_out, 64'hDEAD);
        chk("hit_rd_idx", rd_idx, 4'h1);
        chk("hit_rd_tag", rd_tag, 9'h060);
        chk("stale_wr_en", wr_en, 1'b0);
        chk("pf_full_cmd", cmd, BUS_NONE);
        step();
        ret_tag = 4'd5; #1;
        chk("drain5_wr_en", wr_en, 1'b1);
        step();
        ret_tag = 4'd6; #1;
        step();
        ret_tag = 4'd7; #1;
        step();
        ret_tag = 4'd9; #1;
        chk("drain9_idx", wr_idx, 4'h0);
        chk("drain9_tag", wr_tag, 9'h040);
        step();

        // resident line 0x401 skipped, then 0x402 loaded
        grant = 1; pf_valid = 1; response = 4'd10; #1;
        chk("skip_cmd", cmd, BUS_NONE);
        chk("skip_pf_idx", pf_idx, 4'h1);
        chk("skip_pf_tag", pf_tag, 9'h040);
        step();
        grant = 1; response = 4'd10; #1;
        chk("after_skip_addr", mem_addr, 64'h2010);
        step();

        // rejected demand twice, accepted third
        req = 1; addr = 64'h5000; grant = 1; response = 4'd0; #1;
        chk("rej1_cmd", cmd, BUS_LOAD);
        chk("rej1_addr", mem_addr, 64'h5000);
        step();
        req = 1; addr = 64'h5000; grant = 1; response = 4'd0; #1;
        chk("rej2_addr", mem_addr, 64'h5000);
        step();
        req = 1; addr = 64'h5000; grant = 1; response = 4'd2; #1;
        chk("acc_addr", mem_addr, 64'h5000);
        step();
        req = 1; addr = 64'h5000; grant = 1; response = 4'd11; #1;
        chk("no_dup_addr", mem_addr, 64'h5008);
        chk("no_dup_valid", valid_out, 1'b0);
        step();

        // 0xFFF8 miss: prefetch wraps to line 0
        req = 1; addr = 64'hFFF8; grant = 1; response = 4'd12; #1;
        chk("wrap_dmd_addr", mem_addr, 64'hFFF8);
        step();
        ret_tag = 4'd10; #1;
        step();
        ret_tag = 4'd11; #1;
        step();
        grant = 1; response = 4'd13; #1;
        chk("wrap_pf0_addr", mem_addr, 64'h0000);
        chk("wrap_pf0_cmd", cmd, BUS_LOAD);
        chk("wrap_pf0_idx", pf_idx, 4'h0);
        chk("wrap_pf0_tag", pf_tag, 9'h000);
        step();
        grant = 1; response = 4'd14; #1;
        chk("wrap_pf1_addr", mem_addr, 64'h0008);
        step();

        // reset with loads outstanding (tags 2, 12, 13, 14)
        reset = 1'b0;
        req = 1; addr = 64'h5000; grant = 1; response = 4'd15; ret_tag = 4'd2; ret_data = D0; #1;
        chk("mid_rst_valid", valid_out, 1'b0);
        chk("mid_rst_data", data_out, 64'd0);
        chk("mid_rst_wr_en", wr_en, 1'b0);
        chk("mid_rst_cmd", cmd, BUS_NONE);
        step();
        step(); reset = 1'b1;
        ret_tag = 4'd12; ret_data = D1; #1;
        chk("post_rst_stale_wr", wr_en, 1'b0);
        step();
        req = 1; addr = 64'h0000; ret_tag = 4'd13; ret_data = D1; #1;
        chk("post_rst_no_fwd", valid_out, 1'b0);
        chk("post_rst_wr2", wr_en, 1'b0);
        step();
        grant = 1; response = 4'd3; #1;
        chk("post_rst_idle", cmd, BUS_NONE);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
